sdr_ch3_arbiter: RTL and testbench
==================================

# sdr_ch3_arbiter

Shares SDRAM channel 3 between three requesters: the ROM loader write stream, the BG2 tile-ROM read port and the tilemap read port. It sits between those clients and the `sdram` controller's `ch3_*` port, replacing the fixed download/BG2 mux. It provides strict-priority ROM writes, round-robin reads, per-port data holding registers and a watchdog so a lost `ch3_ready` cannot hang video fetch.

## Interface
Parameters:
- `TIMEOUT`, 64: cycles in WAIT without `ch_ready` before the watchdog aborts; minimum 4.
- `ERR_DATA`, 16'hFFFF: data returned to a read port on watchdog abort.

Ports:
- `clk` in 1: sole clock, the SDRAM-domain `sdr_clk`.
- `reset` in 1: synchronous, active-high.
- `rom_download` in 1: while high, read ports are not granted.
- `rom_req` in 1, `rom_addr` in 25, `rom_data` in 16, `rom_be` in 2: ROM write request, byte address.
- `rom_rdy` out 1: one-cycle completion pulse for the ROM write.
- `bg2_req` in 1, `bg2_addr` in 25: BG2 read request.
- `bg2_rdy` out 1, `bg2_dout` out 16: BG2 completion pulse and held read data.
- `map_req` in 1, `map_addr` in 25: tilemap read request.
- `map_rdy` out 1, `map_dout` out 16: tilemap completion pulse and held read data.
- `ch_addr` out 24, `ch_din` out 16, `ch_be` out 2, `ch_rnw` out 1, `ch_req` out 1: channel command; `ch_addr` is the word address, byte address [24:1].
- `ch_dout` in 16, `ch_ready` in 1: channel response.
- `timeout_err` out 1: sticky flag, set on any watchdog abort.

## Operation
- States are IDLE and WAIT. The grant register `gnt` is one of NONE, ROM, BG2 or MAP.
- Request handshake: a client holds `*_req` high until its `*_rdy` pulse and drops it in the same cycle `*_rdy` is high. The arbiter masks any port whose `*_rdy` is high in the current cycle.
- IDLE arbitration, evaluated every cycle:
  - `rom_req` always wins.
  - Otherwise, if `rom_download` is low, choose between `bg2_req` and `map_req` by round-robin. The pointer `last_rd` favours the port not granted last; its reset value makes BG2 preferred.
  - On any grant, register the command and go to WAIT.
- Command registers:
  - `ch_addr` is `addr[24:1]`.
  - ROM grant: `ch_rnw`=0, `ch_din`=`rom_data`, `ch_be`=`rom_be`.
  - Read grant: `ch_rnw`=1, `ch_be`=2'b11, and `ch_din` holds its previous value.
  - `ch_addr`, `ch_din`, `ch_be` and `ch_rnw` stay stable from grant until the next grant.
- `ch_req` is high for exactly the first cycle of WAIT.
- WAIT:
  - `ch_ready` high: pulse the granted `*_rdy`. A read loads `*_dout` from `ch_dout`; a read updates `last_rd`. Return to IDLE.
  - Watchdog counter reaches `TIMEOUT` without `ch_ready`: abort the access. Pulse the granted `*_rdy`; a read loads `ERR_DATA`. Set `timeout_err` and return to IDLE.
- `*_dout` holds its value until that port's next completion.
- `rom_download` rising while a read is in WAIT: the read completes normally, and no further reads are granted.
- `ch_ready` seen in IDLE is a stray pulse and is ignored.
- Reset values: state IDLE, `gnt` NONE, `ch_req` 0, `ch_rnw` 1, `ch_addr` 0, `ch_din` 0, `ch_be` 0, all `*_rdy` 0, `bg2_dout` 0, `map_dout` 0, `timeout_err` 0, watchdog counter 0, `last_rd` set so BG2 is preferred.
- Reset mid-WAIT abandons the access, and no `*_rdy` is issued. A late `ch_ready` then arrives in IDLE and is ignored.

## Timing
- Request high in IDLE at cycle t: `ch_req` is high in cycle t+1 with the command valid.
- `ch_ready` high at cycle m in WAIT: `*_rdy` and valid `*_dout` in cycle m+1, state IDLE in m+1.
- Next grant is registered at the end of m+1, so the next `ch_req` is at m+2 at the earliest.
- Best-case throughput is one access per 3 cycles plus SDRAM latency.
- Watchdog counts the WAIT cycles starting at t+1. Abort `*_rdy` is in cycle t+1+`TIMEOUT`.
- `ch_ready` arriving in the same cycle the counter expires counts as a normal completion: real data, no error.
- All outputs are registered; there are no combinational paths from input to output.

## Test plan
- Single BG2 read, `bg2_addr`=25'h0040002, `ch_ready` 5 cycles after `ch_req`, `ch_dout`=16'hBEEF:
  - `ch_addr`=24'h020001, `ch_rnw`=1, `ch_req` for exactly 1 cycle.
  - `bg2_rdy` for 1 cycle; `bg2_dout`=16'hBEEF, held until the next BG2 completion.
- BG2 and MAP continuously requesting:
  - grants alternate BG2, MAP, BG2, MAP; neither port gets two consecutive grants.
- ROM write, `rom_data`=16'h1234 `rom_be`=2'b01, raised while a MAP read is in WAIT with BG2 pending:
  - MAP completes first, then ROM is granted with `ch_rnw`=0 `ch_din`=16'h1234 `ch_be`=2'b01, then BG2.
- `rom_download`=1 with `bg2_req` held high for 100 cycles:
  - no BG2 grant; BG2 is granted the cycle after `rom_download` falls.
- `TIMEOUT`=8, MAP read, `ch_ready` never asserted:
  - `map_rdy` in cycle t+9, `map_dout`=16'hFFFF, `timeout_err`=1.
  - A subsequent BG2 read proceeds normally.
- `reset` pulsed mid-WAIT, then `ch_ready` 2 cycles later:
  - all outputs return to reset values; no `*_rdy` pulse; the arbiter accepts a new request normally afterwards.

Source files
------------

// File: rtl/sdr_ch3_arbiter.sv
// SDRAM channel 3 arbiter: ROM loader writes take strict priority, BG2 and
// tilemap reads share the channel round-robin, and a watchdog aborts any
// access whose ch_ready never arrives so video fetch cannot hang.
//
// state  | meaning
// IDLE   | arbitrating; no access outstanding
// WAIT   | command issued, waiting for ch_ready or watchdog expiry
module sdr_ch3_arbiter #(
  parameter int          TIMEOUT  = 64,
  parameter logic [15:0] ERR_DATA = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rom_download,
  input  logic        rom_req,
  input  logic [24:0] rom_addr,
  input  logic [15:0] rom_data,
  input  logic [1:0]  rom_be,
  output logic        rom_rdy,
  input  logic        bg2_req,
  input  logic [24:0] bg2_addr,
  output logic        bg2_rdy,
  output logic [15:0] bg2_dout,
  input  logic        map_req,
  input  logic [24:0] map_addr,
  output logic        map_rdy,
  output logic [15:0] map_dout,
  output logic [23:0] ch_addr,
  output logic [15:0] ch_din,
  output logic [1:0]  ch_be,
  output logic        ch_rnw,
  output logic        ch_req,
  input  logic [15:0] ch_dout,
  input  logic        ch_ready,
  output logic        timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;
  typedef enum logic [1:0] {G_NONE, G_ROM, G_BG2, G_MAP} gnt_t;

  state_t        state, state_n;
  gnt_t          gnt, gnt_n, sel;
  logic [CW-1:0] wdog, wdog_n;
  // 0: BG2 preferred on a tie, 1: MAP preferred
  logic          last_rd, last_rd_n;
  logic [23:0]   ch_addr_n;
  logic [15:0]   ch_din_n, bg2_dout_n, map_dout_n;
  logic [1:0]    ch_be_n;
  logic          ch_rnw_n, ch_req_n, err_n;
  logic          rom_rdy_n, bg2_rdy_n, map_rdy_n;
  logic          rom_v, bg2_v, map_v;

  // Byte-address bit 0 never reaches the word-addressed channel.
  logic unused_bits;
  assign unused_bits = ^{rom_addr[0], bg2_addr[0], map_addr[0]};

  // A port completing this cycle is still raising req; ignore it until it drops.
  assign rom_v = rom_req & ~rom_rdy;
  assign bg2_v = bg2_req & ~bg2_rdy;
  assign map_v = map_req & ~map_rdy;

  // Arbitration, command capture and completion handling.
  always_comb begin
    state_n    = state;
    gnt_n      = gnt;
    wdog_n     = wdog;
    last_rd_n  = last_rd;
    ch_addr_n  = ch_addr;
    ch_din_n   = ch_din;
    ch_be_n    = ch_be;
    ch_rnw_n   = ch_rnw;
    ch_req_n   = 1'b0;
    err_n      = timeout_err;
    bg2_dout_n = bg2_dout;
    map_dout_n = map_dout;
    rom_rdy_n  = 1'b0;
    bg2_rdy_n  = 1'b0;
    map_rdy_n  = 1'b0;
    sel        = G_NONE;

    unique case (state)
      S_IDLE: begin
        if (rom_v)
          sel = G_ROM;
        else if (!rom_download) begin
          if (bg2_v && map_v) sel = last_rd ? G_MAP : G_BG2;
          else if (bg2_v)     sel = G_BG2;
          else if (map_v)     sel = G_MAP;
        end

        if (sel != G_NONE) begin
          state_n  = S_WAIT;
          gnt_n    = sel;
          ch_req_n = 1'b1;
          wdog_n   = CW'(TIMEOUT - 1);
          if (sel == G_ROM) begin
            ch_addr_n = rom_addr[24:1];
            ch_din_n  = rom_data;
            ch_be_n   = rom_be;
            ch_rnw_n  = 1'b0;
          end else begin
            ch_addr_n = (sel == G_BG2) ? bg2_addr[24:1] : map_addr[24:1];
            ch_be_n   = 2'b11;
            ch_rnw_n  = 1'b1;
          end
        end
      end

      S_WAIT: begin
        if (ch_ready || wdog == '0) begin
          state_n = S_IDLE;
          gnt_n   = G_NONE;
          rom_rdy_n = (gnt == G_ROM);
          bg2_rdy_n = (gnt == G_BG2);
          map_rdy_n = (gnt == G_MAP);
          if (ch_ready) begin
            if (gnt == G_BG2) begin
              bg2_dout_n = ch_dout;
              last_rd_n  = 1'b1;
            end
            if (gnt == G_MAP) begin
              map_dout_n = ch_dout;
              last_rd_n  = 1'b0;
            end
          end else begin
            err_n = 1'b1;
            if (gnt == G_BG2) bg2_dout_n = ERR_DATA;
            if (gnt == G_MAP) map_dout_n = ERR_DATA;
          end
        end else begin
          wdog_n = wdog - 1'b1;
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any outstanding access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      gnt         <= G_NONE;
      wdog        <= '0;
      last_rd     <= 1'b0;
      ch_addr     <= '0;
      ch_din      <= '0;
      ch_be       <= '0;
      ch_rnw      <= 1'b1;
      ch_req      <= 1'b0;
      timeout_err <= 1'b0;
      bg2_dout    <= '0;
      map_dout    <= '0;
      rom_rdy     <= 1'b0;
      bg2_rdy     <= 1'b0;
      map_rdy     <= 1'b0;
    end else begin
      state       <= state_n;
      gnt         <= gnt_n;
      wdog        <= wdog_n;
      last_rd     <= last_rd_n;
      ch_addr     <= ch_addr_n;
      ch_din      <= ch_din_n;
      ch_be       <= ch_be_n;
      ch_rnw      <= ch_rnw_n;
      ch_req      <= ch_req_n;
      timeout_err <= err_n;
      bg2_dout    <= bg2_dout_n;
      map_dout    <= map_dout_n;
      rom_rdy     <= rom_rdy_n;
      bg2_rdy     <= bg2_rdy_n;
      map_rdy     <= map_rdy_n;
    end
  end

endmodule

// File: tb/tb_sdr_ch3_arbiter.sv
// Directed bench for sdr_ch3_arbiter with a short watchdog (TIMEOUT=8).
module tb_sdr_ch3_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rom_download = 1'b0;
  logic        rom_req = 1'b0;
  logic [24:0] rom_addr = '0;
  logic [15:0] rom_data = '0;
  logic [1:0]  rom_be = '0;
  logic        rom_rdy;
  logic        bg2_req = 1'b0;
  logic [24:0] bg2_addr = '0;
  logic        bg2_rdy;
  logic [15:0] bg2_dout;
  logic        map_req = 1'b0;
  logic [24:0] map_addr = '0;
  logic        map_rdy;
  logic [15:0] map_dout;
  logic [23:0] ch_addr;
  logic [15:0] ch_din;
  logic [1:0]  ch_be;
  logic        ch_rnw;
  logic        ch_req;
  logic [15:0] ch_dout = '0;
  logic        ch_ready = 1'b0;
  logic        timeout_err;

  int vecs = 0;
  int errs = 0;

  sdr_ch3_arbiter #(.TIMEOUT(8), .ERR_DATA(16'hFFFF)) dut (
    .clk(clk), .reset(reset), .rom_download(rom_download),
    .rom_req(rom_req), .rom_addr(rom_addr), .rom_data(rom_data), .rom_be(rom_be),
    .rom_rdy(rom_rdy),
    .bg2_req(bg2_req), .bg2_addr(bg2_addr), .bg2_rdy(bg2_rdy), .bg2_dout(bg2_dout),
    .map_req(map_req), .map_addr(map_addr), .map_rdy(map_rdy), .map_dout(map_dout),
    .ch_addr(ch_addr), .ch_din(ch_din), .ch_be(ch_be), .ch_rnw(ch_rnw), .ch_req(ch_req),
    .ch_dout(ch_dout), .ch_ready(ch_ready), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Advance until ch_req is seen, bounded.
  task automatic wait_req(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!ch_req && n < 50);
    chk(tag, {31'd0, ch_req}, 32'd1);
  endtask

  // Called in the ch_req cycle; ends in the cycle where *_rdy should be high.
  task automatic respond(input int lat, input logic [15:0] d);
    repeat (lat) tick();
    ch_ready = 1'b1;
    ch_dout  = d;
    tick();
    ch_ready = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ch_req"},  {31'd0, ch_req}, 32'd0);
    chk({tag, "_ch_rnw"},  {31'd0, ch_rnw}, 32'd1);
    chk({tag, "_ch_addr"}, {8'd0, ch_addr}, 32'd0);
    chk({tag, "_ch_din"},  {16'd0, ch_din}, 32'd0);
    chk({tag, "_ch_be"},   {30'd0, ch_be}, 32'd0);
    chk({tag, "_rdys"},    {29'd0, rom_rdy, bg2_rdy, map_rdy}, 32'd0);
    chk({tag, "_douts"},   {bg2_dout, map_dout}, 32'd0);
    chk({tag, "_err"},     {31'd0, timeout_err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int cnt;
    logic [23:0] exp_addr;

    // Reset values
    do_reset();
    chk_reset_vals("rst");

    // Single BG2 read, ready 5 cycles after ch_req
    bg2_addr = 25'h0040002;
    bg2_req  = 1'b1;
    tick();
    chk("bg2_req1", {31'd0, ch_req}, 32'd1);
    chk("bg2_addr", {8'd0, ch_addr}, 32'h020001);
    chk("bg2_rnw",  {31'd0, ch_rnw}, 32'd1);
    chk("bg2_be",   {30'd0, ch_be}, 32'd3);
    cnt = 0;
    repeat (4) begin
      tick();
      if (ch_req || bg2_rdy) cnt++;
    end
    chk("bg2_req_once", cnt, 32'd0);
    ch_ready = 1'b1;
    ch_dout  = 16'hBEEF;
    tick();
    ch_ready = 1'b0;
    chk("bg2_rdy", {31'd0, bg2_rdy}, 32'd1);
    chk("bg2_dout", {16'd0, bg2_dout}, 32'hBEEF);
    bg2_req = 1'b0;
    ch_dout = 16'h0000;
    tick();
    chk("bg2_rdy_pulse", {31'd0, bg2_rdy}, 32'd0);
    repeat (3) tick();
    chk("bg2_dout_hold", {16'd0, bg2_dout}, 32'hBEEF);

    // Round-robin with both reads requesting continuously
    do_reset();
    bg2_addr = 25'h0000010;
    map_addr = 25'h0000100;
    bg2_req  = 1'b1;
    map_req  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_req($sformatf("rr_req%0d", i));
      exp_addr = (i % 2 == 0) ? 24'h000008 : 24'h000080;
      chk($sformatf("rr_addr%0d", i), {8'd0, ch_addr}, {8'd0, exp_addr});
      respond(1, 16'h1000 + 16'(i));
      if (i % 2 == 0) chk($sformatf("rr_rdy%0d", i), {bg2_rdy, map_rdy, bg2_dout}, {2'b10, 16'h1000 + 16'(i)});
      else            chk($sformatf("rr_rdy%0d", i), {bg2_rdy, map_rdy, map_dout}, {2'b01, 16'h1000 + 16'(i)});
      if (i == 3) begin
        bg2_req = 1'b0;
        map_req = 1'b0;
      end
    end
    tick();
    tick();
    chk("rr_idle", {31'd0, ch_req}, 32'd0);

    // ROM write raised during a MAP read, with BG2 pending
    map_req = 1'b1;
    wait_req("rom_map_req");
    chk("rom_map_addr", {8'd0, ch_addr}, 32'h000080);
    bg2_req  = 1'b1;
    rom_addr = 25'h0000200;
    rom_data = 16'h1234;
    rom_be   = 2'b01;
    rom_req  = 1'b1;
    respond(2, 16'h5555);
    chk("rom_map_done", {map_rdy, rom_rdy, map_dout}, {2'b10, 16'h5555});
    map_req = 1'b0;
    wait_req("rom_req");
    chk("rom_cmd", {ch_rnw, ch_be, ch_din, 5'd0, ch_addr[7:0]}, {1'b0, 2'b01, 16'h1234, 5'd0, 8'h00});
    chk("rom_addr", {8'd0, ch_addr}, 32'h000100);
    respond(1, 16'h0000);
    chk("rom_rdy", {29'd0, rom_rdy, bg2_rdy, map_rdy}, 32'b100);
    rom_req = 1'b0;
    wait_req("rom_bg2_req");
    chk("rom_bg2_cmd", {ch_rnw, ch_be, ch_din}, {1'b1, 2'b11, 16'h1234});
    chk("rom_bg2_addr", {8'd0, ch_addr}, 32'h000008);
    respond(1, 16'h6666);
    chk("rom_bg2_done", {bg2_rdy, bg2_dout}, {1'b1, 16'h6666});
    bg2_req = 1'b0;
    tick();

    // rom_download blocks reads
    rom_download = 1'b1;
    bg2_req = 1'b1;
    cnt = 0;
    repeat (100) begin
      tick();
      if (ch_req) cnt++;
    end
    chk("dl_block", cnt, 32'd0);
    rom_download = 1'b0;
    tick();
    chk("dl_release", {31'd0, ch_req}, 32'd1);
    respond(1, 16'h7070);
    chk("dl_bg2_done", {bg2_rdy, bg2_dout}, {1'b1, 16'h7070});
    bg2_req = 1'b0;
    tick();

    // ch_ready in the expiry cycle is a normal completion
    map_req = 1'b1;
    wait_req("edge_req");
    respond(7, 16'h7777);
    chk("edge_done", {map_rdy, timeout_err, map_dout}, {2'b10, 16'h7777});
    map_req = 1'b0;
    tick();

    // Watchdog abort on a MAP read
    map_req = 1'b1;
    tick();
    chk("to_req", {31'd0, ch_req}, 32'd1);
    cnt = 0;
    repeat (7) begin
      tick();
      if (map_rdy) cnt++;
    end
    chk("to_early", cnt, 32'd0);
    tick();
    chk("to_rdy", {map_rdy, timeout_err, map_dout}, {2'b11, 16'hFFFF});
    map_req = 1'b0;
    bg2_req = 1'b1;
    wait_req("to_bg2_req");
    respond(3, 16'hA5A5);
    chk("to_bg2_done", {bg2_rdy, timeout_err, bg2_dout}, {2'b11, 16'hA5A5});
    bg2_req = 1'b0;
    tick();

    // Reset during WAIT, late ch_ready afterwards
    bg2_req = 1'b1;
    wait_req("rw_req");
    tick();
    reset   = 1'b1;
    bg2_req = 1'b0;
    tick();
    reset = 1'b0;
    chk_reset_vals("rw");
    tick();
    ch_ready = 1'b1;
    ch_dout  = 16'h1111;
    tick();
    ch_ready = 1'b0;
    cnt = 0;
    repeat (4) begin
      if (rom_rdy || bg2_rdy || map_rdy || ch_req) cnt++;
      tick();
    end
    chk("rw_stray", cnt, 32'd0);
    chk("rw_douts", {bg2_dout, map_dout}, 32'd0);
    map_addr = 25'h0000100;
    map_req  = 1'b1;
    wait_req("rw_new_req");
    chk("rw_new_addr", {8'd0, ch_addr}, 32'h000080);
    respond(2, 16'h2222);
    chk("rw_new_done", {map_rdy, map_dout}, {1'b1, 16'h2222});
    map_req = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
